hdmi_pattern_gen: RTL and testbench

- Synthesizable video source that drives the hdmi_clk-domain video bus (hs/vs/de/32-bit data) into the downstream frame logger and into the display output path.
- Generates 640x480@60 timing and a selectable test pattern, so the downstream sink can be exercised without a camera.
- Provides pixel coordinates and a frame counter for tracker debug.

---
 rtl/hdmi_video_pkg.sv | 53 +++++
 rtl/hdmi_timing_cnt.sv | 70 +++++++
 rtl/hdmi_pattern_gen.sv | 171 +++++++++++++++++
 tb/tb_hdmi_pattern_gen.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_video_pkg.sv
// Shared raster defaults, pattern encodings and colours for the hdmi video source.
// Pure definitions: no logic, no latency, no flow control.
package hdmi_video_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int CNT_W = 10;

    typedef enum logic [1:0] {
        PAT_BARS  = 2'd0,
        PAT_GRAD  = 2'd1,
        PAT_CHECK = 2'd2,
        PAT_FRAME = 2'd3
    } pat_e;

    localparam logic [23:0] COL_WHITE   = 24'hFFFFFF;
    localparam logic [23:0] COL_YELLOW  = 24'hFFFF00;
    localparam logic [23:0] COL_CYAN    = 24'h00FFFF;
    localparam logic [23:0] COL_GREEN   = 24'h00FF00;
    localparam logic [23:0] COL_MAGENTA = 24'hFF00FF;
    localparam logic [23:0] COL_RED     = 24'hFF0000;
    localparam logic [23:0] COL_BLUE    = 24'h0000FF;
    localparam logic [23:0] COL_BLACK   = 24'h000000;

    function automatic int raster_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    localparam int H_TOTAL = raster_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
    localparam int V_TOTAL = raster_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

    // Index 7 and anything past the last bar fall through to black.
    function automatic logic [23:0] bar_colour(input logic [CNT_W-1:0] idx);
        case (idx)
            10'd0:   return COL_WHITE;
            10'd1:   return COL_YELLOW;
            10'd2:   return COL_CYAN;
            10'd3:   return COL_GREEN;
            10'd4:   return COL_MAGENTA;
            10'd5:   return COL_RED;
            10'd6:   return COL_BLUE;
            default: return COL_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/hdmi_timing_cnt.sv
// Raster h/v counters with active and sync decode; decode is combinational from counter state.
// enable low clears both counters on the next clock; no backpressure, free-running when enabled.
module hdmi_timing_cnt
    import hdmi_video_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             enable_i,
    output logic [CNT_W-1:0] h_cnt_o,
    output logic [CNT_W-1:0] v_cnt_o,
    output logic             active_o,
    output logic             hs_n_o,
    output logic             vs_n_o,
    output logic             first_pix_o,
    output logic             vs_start_o
);

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(raster_total(H_ACTIVE, H_FP, H_SYNC, H_BP) - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(raster_total(V_ACTIVE, V_FP, V_SYNC, V_BP) - 1);
    localparam logic [CNT_W-1:0] HA     = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] VA     = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [CNT_W-1:0] h_q, h_d, v_q, v_d;

    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (!enable_i) begin
            h_d = '0;
            v_d = '0;
        end else if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
        end else begin
            h_d = h_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    assign h_cnt_o     = h_q;
    assign v_cnt_o     = v_q;
    assign active_o    = (h_q < HA) && (v_q < VA);
    assign hs_n_o      = !((h_q >= HS_BEG) && (h_q < HS_END));
    assign vs_n_o      = !((v_q >= VS_BEG) && (v_q < VS_END));
    assign first_pix_o = (h_q == '0) && (v_q == '0);
    assign vs_start_o  = (h_q == '0) && (v_q == VS_BEG);

endmodule

// File: rtl/hdmi_pattern_gen.sv
// 640x480@60 video source with selectable test pattern; all outputs registered 1 clock after counter state.
// No backpressure; enable low idles outputs. Optional marker overlay under MARKER_OVERLAY_EN.
module hdmi_pattern_gen
    import hdmi_video_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic             hdmi_clk,
    input  logic             hdmi_rst_n,
    input  logic             enable,
    input  logic [1:0]       pattern_sel,
`ifdef MARKER_OVERLAY_EN
    input  logic [CNT_W-1:0] marker_x,
    input  logic [CNT_W-1:0] marker_y,
    input  logic             marker_valid,
`endif
    output logic             hdmi_hs,
    output logic             hdmi_vs,
    output logic             hdmi_de,
    output logic [31:0]      hdmi_data,
    output logic [CNT_W-1:0] pix_x,
    output logic [CNT_W-1:0] pix_y,
    output logic [7:0]       frame_cnt,
    output logic             frame_start
);

    localparam logic [CNT_W-1:0] BAR_W = CNT_W'(H_ACTIVE / 8);

    logic [CNT_W-1:0] h_cnt, v_cnt;
    logic             active, hs_n, vs_n, first_pix, vs_start;

    hdmi_timing_cnt #(
        .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
    ) u_timing (
        .clk_i       (hdmi_clk),
        .rst_ni      (hdmi_rst_n),
        .enable_i    (enable),
        .h_cnt_o     (h_cnt),
        .v_cnt_o     (v_cnt),
        .active_o    (active),
        .hs_n_o      (hs_n),
        .vs_n_o      (vs_n),
        .first_pix_o (first_pix),
        .vs_start_o  (vs_start)
    );

    logic             hs_q, hs_d, vs_q, vs_d, de_q, de_d, fs_q, fs_d;
    logic [23:0]      rgb_q, rgb_d, pat_rgb, pix_rgb;
    logic [CNT_W-1:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
    logic [7:0]       frame_cnt_q, frame_cnt_d;
    pat_e             pat_q, pat_d, pat_cur;

    // Pixel (0,0) already uses the newly selected pattern, so bypass the latch there.
    assign pat_cur = first_pix ? pat_e'(pattern_sel) : pat_q;

    always_comb begin
        pat_rgb = COL_BLACK;
        case (pat_cur)
            PAT_BARS:  pat_rgb = bar_colour(h_cnt / BAR_W);
            PAT_GRAD:  pat_rgb = {3{h_cnt[9:2]}};
            PAT_CHECK: pat_rgb = (h_cnt[5] ^ v_cnt[5]) ? COL_WHITE : COL_BLACK;
            PAT_FRAME: pat_rgb = {frame_cnt_q, 8'h00, ~frame_cnt_q};
            default:   pat_rgb = COL_BLACK;
        endcase
    end

`ifdef MARKER_OVERLAY_EN
    localparam int MK_W = CNT_W + 2;
    localparam logic signed [MK_W-1:0] RING = MK_W'(4);

    logic [CNT_W-1:0]        mk_x_q, mk_y_q, mk_x, mk_y;
    logic                    mk_vld_q, mk_vld;
    logic signed [MK_W-1:0]  dx, dy, adx, ady;
    logic                    on_ring;

    assign mk_x   = first_pix ? marker_x     : mk_x_q;
    assign mk_y   = first_pix ? marker_y     : mk_y_q;
    assign mk_vld = first_pix ? marker_valid : mk_vld_q;

    // Signed offsets keep a marker near an edge from wrapping onto the far side.
    assign dx      = $signed({2'b00, h_cnt}) - $signed({2'b00, mk_x});
    assign dy      = $signed({2'b00, v_cnt}) - $signed({2'b00, mk_y});
    assign adx     = dx[MK_W-1] ? -dx : dx;
    assign ady     = dy[MK_W-1] ? -dy : dy;
    assign on_ring = mk_vld && (adx <= RING) && (ady <= RING) && ((adx == RING) || (ady == RING));
    assign pix_rgb = on_ring ? COL_GREEN : pat_rgb;

    always_ff @(posedge hdmi_clk or negedge hdmi_rst_n) begin
        if (!hdmi_rst_n) begin
            mk_x_q   <= '0;
            mk_y_q   <= '0;
            mk_vld_q <= 1'b0;
        end else if (enable && first_pix) begin
            mk_x_q   <= marker_x;
            mk_y_q   <= marker_y;
            mk_vld_q <= marker_valid;
        end
    end
`else
    assign pix_rgb = pat_rgb;
`endif

    always_comb begin
        hs_d        = 1'b1;
        vs_d        = 1'b1;
        de_d        = 1'b0;
        fs_d        = 1'b0;
        rgb_d       = '0;
        pix_x_d     = '0;
        pix_y_d     = '0;
        frame_cnt_d = frame_cnt_q;
        pat_d       = pat_q;
        if (enable) begin
            hs_d    = hs_n;
            vs_d    = vs_n;
            de_d    = active;
            fs_d    = first_pix;
            pat_d   = pat_cur;
            pix_x_d = pix_x_q;
            pix_y_d = pix_y_q;
            if (active) begin
                rgb_d   = pix_rgb;
                pix_x_d = h_cnt;
                pix_y_d = v_cnt;
            end
            if (vs_start) frame_cnt_d = frame_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge hdmi_clk or negedge hdmi_rst_n) begin
        if (!hdmi_rst_n) begin
            hs_q        <= 1'b1;
            vs_q        <= 1'b1;
            de_q        <= 1'b0;
            fs_q        <= 1'b0;
            rgb_q       <= '0;
            pix_x_q     <= '0;
            pix_y_q     <= '0;
            frame_cnt_q <= '0;
            pat_q       <= PAT_BARS;
        end else begin
            hs_q        <= hs_d;
            vs_q        <= vs_d;
            de_q        <= de_d;
            fs_q        <= fs_d;
            rgb_q       <= rgb_d;
            pix_x_q     <= pix_x_d;
            pix_y_q     <= pix_y_d;
            frame_cnt_q <= frame_cnt_d;
            pat_q       <= pat_d;
        end
    end

    assign hdmi_hs     = hs_q;
    assign hdmi_vs     = vs_q;
    assign hdmi_de     = de_q;
    assign hdmi_data   = {8'h00, rgb_q};
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign frame_cnt   = frame_cnt_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_hdmi_pattern_gen.sv
// Bench for hdmi_pattern_gen on a shrunk raster, plus a tiny raster instance for frame counter wrap.
module tb_hdmi_pattern_gen;

    localparam int HA = 64, HFP = 4, HSY = 8, HBP = 4;
    localparam int VA = 40, VFP = 2, VSY = 2, VBP = 4;
    localparam int HT = HA + HFP + HSY + HBP;
    localparam int VT = VA + VFP + VSY + VBP;
    localparam int FR = HT * VT;
    localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                         24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    logic        hdmi_clk = 1'b0;
    logic        rst_n, rst2_n, enable;
    logic [1:0]  pattern_sel;
    logic        hdmi_hs, hdmi_vs, hdmi_de, frame_start;
    logic [31:0] hdmi_data;
    logic [9:0]  pix_x, pix_y;
    logic [7:0]  frame_cnt;
    logic        t_hs, t_vs, t_de, t_fs;
    logic [31:0] t_data;
    logic [9:0]  t_px, t_py;
    logic [7:0]  t_fc;
`ifdef MARKER_OVERLAY_EN
    logic [9:0]  mk_x, mk_y;
    logic        mk_v;
`endif

    always #5 hdmi_clk = ~hdmi_clk;

    hdmi_pattern_gen #(
        .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HSY), .H_BP (HBP),
        .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VSY), .V_BP (VBP)
    ) dut (
        .hdmi_clk    (hdmi_clk),
        .hdmi_rst_n  (rst_n),
        .enable      (enable),
        .pattern_sel (pattern_sel),
`ifdef MARKER_OVERLAY_EN
        .marker_x    (mk_x),
        .marker_y    (mk_y),
        .marker_valid(mk_v),
`endif
        .hdmi_hs     (hdmi_hs),
        .hdmi_vs     (hdmi_vs),
        .hdmi_de     (hdmi_de),
        .hdmi_data   (hdmi_data),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .frame_cnt   (frame_cnt),
        .frame_start (frame_start)
    );

    hdmi_pattern_gen #(
        .H_ACTIVE (8), .H_FP (1), .H_SYNC (2), .H_BP (1),
        .V_ACTIVE (2), .V_FP (1), .V_SYNC (1), .V_BP (1)
    ) dut_tiny (
        .hdmi_clk    (hdmi_clk),
        .hdmi_rst_n  (rst2_n),
        .enable      (1'b1),
        .pattern_sel (2'd0),
`ifdef MARKER_OVERLAY_EN
        .marker_x    (10'd0),
        .marker_y    (10'd0),
        .marker_valid(1'b0),
`endif
        .hdmi_hs     (t_hs),
        .hdmi_vs     (t_vs),
        .hdmi_de     (t_de),
        .hdmi_data   (t_data),
        .pix_x       (t_px),
        .pix_y       (t_py),
        .frame_cnt   (t_fc),
        .frame_start (t_fs)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [23:0] m_col(input logic [1:0] p, input int x, input int y, input logic [7:0] fc);
        case (p)
            2'd0:    return BARS[x / (HA / 8)];
            2'd1:    return {3{8'(x / 4)}};
            2'd2:    return ((((x / 32) + (y / 32)) % 2) == 1) ? 24'hFFFFFF : 24'h000000;
            default: return {fc, 8'h00, ~fc};
        endcase
    endfunction

    function automatic bit m_ring(input int dx, input int dy);
        int ax, ay;
        ax = (dx < 0) ? -dx : dx;
        ay = (dy < 0) ? -dy : dy;
        return (ax <= 4) && (ay <= 4) && ((ax == 4) || (ay == 4));
    endfunction

    // Cycle model: expected output word pushed at each edge, popped once the DUT has updated.
    logic [63:0] sb_q[$];
    logic [63:0] m_exp;
    int          mh, mv;
    logic [7:0]  m_fc;
    logic [1:0]  m_pat;
    logic [9:0]  m_px, m_py;
    logic [23:0] m_c;
    logic        m_act;
    int          m_mx, m_my;
    bit          m_mv;

    always @(posedge hdmi_clk) begin
        if (!rst_n) begin
            mh = 0; mv = 0; m_fc = 8'd0; m_pat = 2'd0; m_px = '0; m_py = '0; m_mv = 0;
            m_exp = {1'b1, 1'b1, 1'b0, 32'h0, 10'h0, 10'h0, 8'h0, 1'b0};
        end else if (!enable) begin
            mh = 0; mv = 0; m_px = '0; m_py = '0;
            m_exp = {1'b1, 1'b1, 1'b0, 32'h0, 10'h0, 10'h0, m_fc, 1'b0};
        end else begin
            if (mh == 0 && mv == 0) begin
                m_pat = pattern_sel;
`ifdef MARKER_OVERLAY_EN
                m_mx = int'(mk_x); m_my = int'(mk_y); m_mv = mk_v;
`endif
            end
            m_act = (mh < HA) && (mv < VA);
            if (mh == 0 && mv == VA + VFP) m_fc = m_fc + 8'd1;
            m_c = 24'h0;
            if (m_act) begin
                m_px = 10'(mh);
                m_py = 10'(mv);
                m_c  = m_col(m_pat, mh, mv, m_fc);
                if (m_mv && m_ring(mh - m_mx, mv - m_my)) m_c = 24'h00FF00;
            end
            m_exp = {!(mh >= HA + HFP && mh < HA + HFP + HSY), !(mv >= VA + VFP && mv < VA + VFP + VSY),
                     m_act, 8'h00, m_c, m_px, m_py, m_fc, (mh == 0 && mv == 0)};
            mh++;
            if (mh == HT) begin
                mh = 0;
                mv++;
                if (mv == VT) mv = 0;
            end
        end
        sb_q.push_back(m_exp);
        #1;
        check_eq("cyc", {hdmi_hs, hdmi_vs, hdmi_de, hdmi_data, pix_x, pix_y, frame_cnt, frame_start},
                 sb_q.pop_front());
    end

    int   exp_fc2 = 0;
    logic t_vs_prev = 1'b1;
    bit   wrapped = 0;

    always @(posedge hdmi_clk) begin
        #2;
        if (rst2_n) begin
            if (t_vs_prev && !t_vs) begin
                exp_fc2 = (exp_fc2 + 1) % 256;
                check_eq("fc_tiny", t_fc, exp_fc2);
                if (exp_fc2 == 0) wrapped = 1;
            end
            t_vs_prev = t_vs;
        end
    end

    task automatic wait_pix(input int x, input int y, input int budget, output logic [23:0] rgb);
        int  n = 0;
        bit  seen = 0;
        while (!seen && n < budget) begin
            @(posedge hdmi_clk);
            #2;
            n++;
            seen = hdmi_de && (pix_x == 10'(x)) && (pix_y == 10'(y));
        end
        check_eq($sformatf("seen_%0d_%0d", x, y), 64'(seen), 64'd1);
        rgb = hdmi_data[23:0];
    endtask

    // Starts on a frame_start sample and runs to the next one.
    task automatic measure_frame(input string tag);
        int cyc = 0, de_n = 0, hs_lo = 0, vs_lo = 0, hs_off = -1, vs_off = -1;
        bit done = 0;
        while (!done && cyc < 2 * FR) begin
            if (hdmi_de) de_n++;
            if (!hdmi_hs) begin hs_lo++; if (hs_off < 0) hs_off = cyc; end
            if (!hdmi_vs) begin vs_lo++; if (vs_off < 0) vs_off = cyc; end
            cyc++;
            @(posedge hdmi_clk);
            #2;
            done = frame_start;
        end
        check_eq({tag, "_period"}, cyc, FR);
        check_eq({tag, "_de"}, de_n, HA * VA);
        check_eq({tag, "_hs_low"}, hs_lo, HSY * VT);
        check_eq({tag, "_hs_off"}, hs_off, HA + HFP);
        check_eq({tag, "_vs_low"}, vs_lo, VSY * HT);
        check_eq({tag, "_vs_off"}, vs_off, (VA + VFP) * HT);
    endtask

    initial begin
        logic [23:0] rgb;
        rst_n = 1'b0; rst2_n = 1'b0; enable = 1'b1; pattern_sel = 2'd0;
`ifdef MARKER_OVERLAY_EN
        mk_x = 10'd10; mk_y = 10'd10; mk_v = 1'b0;
`endif
        repeat (3) @(negedge hdmi_clk);
        check_eq("rst_out", {hdmi_hs, hdmi_vs, hdmi_de, hdmi_data, pix_x, pix_y, frame_cnt, frame_start},
                 {2'b11, 62'h0});
        rst_n = 1'b1; rst2_n = 1'b1;

        wait_pix(0, 0, 1, rgb);
        check_eq("first_fs", frame_start, 1);
        check_eq("bar_x0", rgb, 24'hFFFFFF);
        measure_frame("f1");
        measure_frame("f2");
        wait_pix(8, 0, FR, rgb);   check_eq("bar_x8", rgb, 24'hFFFF00);
        wait_pix(16, 0, FR, rgb);  check_eq("bar_x16", rgb, 24'h00FFFF);
        wait_pix(63, 0, FR, rgb);  check_eq("bar_x63", rgb, 24'h000000);
        check_eq("data_hi", hdmi_data[31:24], 8'h00);

        wait_pix(0, 10, FR, rgb);
        @(negedge hdmi_clk) pattern_sel = 2'd2;
        wait_pix(0, 20, FR, rgb);  check_eq("sw_old", rgb, 24'hFFFFFF);
        wait_pix(0, 0, FR, rgb);   check_eq("sw_new_00", rgb, 24'h000000);
        wait_pix(32, 0, FR, rgb);  check_eq("sw_new_32", rgb, 24'hFFFFFF);

        @(negedge hdmi_clk) pattern_sel = 2'd1;
        wait_pix(0, 0, FR, rgb);
        wait_pix(40, 3, FR, rgb);  check_eq("grad_40", rgb, 24'h0A0A0A);

`ifdef MARKER_OVERLAY_EN
        @(negedge hdmi_clk) mk_v = 1'b1;
        wait_pix(0, 0, FR, rgb);
        wait_pix(6, 6, FR, rgb);   check_eq("mk_6_6", rgb, 24'h00FF00);
        wait_pix(10, 10, FR, rgb); check_eq("mk_10_10", rgb, 24'h020202);
        wait_pix(14, 10, FR, rgb); check_eq("mk_14_10", rgb, 24'h00FF00);
        @(negedge hdmi_clk) begin mk_x = 10'd0; mk_y = 10'd0; end
        wait_pix(0, 0, FR, rgb);
        wait_pix(4, 0, FR, rgb);   check_eq("mk0_4_0", rgb, 24'h00FF00);
        wait_pix(63, 0, FR, rgb);  check_eq("mk0_63_0", rgb, 24'h0F0F0F);
        @(negedge hdmi_clk) mk_v = 1'b0;
`endif

        @(negedge hdmi_clk) pattern_sel = 2'd3;
        wait_pix(30, 5, 2 * FR, rgb);
        @(negedge hdmi_clk) enable = 1'b0;
        @(posedge hdmi_clk);
        #2;
        check_eq("idle", {hdmi_hs, hdmi_vs, hdmi_de, hdmi_data, frame_start}, {3'b110, 32'h0, 1'b0});
        repeat (3) @(negedge hdmi_clk);
        enable = 1'b1;
        @(posedge hdmi_clk);
        #2;
        check_eq("reen", {hdmi_de, frame_start, pix_x, pix_y}, {2'b11, 20'h0});
        measure_frame("fre");

        wait_pix(10, 10, FR, rgb);
        @(negedge hdmi_clk);
        #2 rst_n = 1'b0;
        #1 check_eq("rst_async", {hdmi_hs, hdmi_vs, hdmi_de, hdmi_data, frame_cnt}, {3'b110, 40'h0});
        @(negedge hdmi_clk) rst_n = 1'b1;
        wait_pix(0, 0, 1, rgb);
        check_eq("rst_first_fs", frame_start, 1);

        for (int i = 0; i < 40000 && !wrapped; i++) @(posedge hdmi_clk);
        check_eq("fc_wrap_seen", 64'(wrapped), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
